icache_controller: RTL

ICACHE_CONTROLLER -- requirements
Module: icache_controller

---
 rtl/icache_controller.sv | 132 +++++++++++++
 1 files changed

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: 16-byte lines, blocking refill from
// instruction memory, flush of all lines, saturating hit/miss statistics.
module icache_controller #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_read,
  input  logic [31:0]      cpu_address,
  input  logic             flush,
  output logic [31:0]      instruction,
  output logic             busywait,
  output logic             mem_read,
  output logic [27:0]      mem_address,
  input  logic [127:0]     mem_readinst,
  input  logic             mem_busywait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned IdxW = $clog2(NUM_SETS);
  localparam int unsigned TagW = 28 - IdxW;

  typedef enum logic [1:0] {StIdle, StMemRead, StUpdate, StFlush} state_e;

  state_e              state_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [TagW-1:0]     tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];
  logic [127:0]        block_q;
  logic                issued_q;
  logic                mem_read_q;
  logic [27:0]         mem_addr_q;
  logic [CNT_W-1:0]    hit_cnt_q;
  logic [CNT_W-1:0]    miss_cnt_q;

  logic [IdxW-1:0] cpu_index;
  logic [TagW-1:0] cpu_tag;
  logic [1:0]      cpu_offset;
  logic [IdxW-1:0] fill_index;
  logic [TagW-1:0] fill_tag;
  logic            hit;
  logic            unused_addr_bits;

  assign cpu_offset       = cpu_address[3:2];
  assign cpu_index        = cpu_address[4 +: IdxW];
  assign cpu_tag          = cpu_address[31 -: TagW];
  assign fill_index       = mem_addr_q[IdxW-1:0];
  assign fill_tag         = mem_addr_q[27 -: TagW];
  // Byte-within-word bits play no part in instruction fetch.
  assign unused_addr_bits = ^cpu_address[1:0];

  // Hit detection, instruction select and stall generation.
  always_comb begin
    hit = cpu_read & valid_q[cpu_index] & (tag_q[cpu_index] == cpu_tag) &
          (state_q == StIdle) & ~flush;
    instruction = '0;
    if (hit) begin
      instruction = data_q[cpu_index][{cpu_offset, 5'b0} +: 32];
    end
    busywait = (state_q != StIdle) | (cpu_read & ~hit);
  end

  assign mem_read    = mem_read_q;
  assign mem_address = mem_addr_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  // Controller FSM with registered memory request, valid bits and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      block_q    <= '0;
      issued_q   <= 1'b0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            state_q <= StFlush;
          end else if (cpu_read && !hit) begin
            state_q    <= StMemRead;
            mem_read_q <= 1'b1;
            issued_q   <= 1'b0;
            mem_addr_q <= cpu_address[31:4];
            if (miss_cnt_q != '1) begin
              miss_cnt_q <= miss_cnt_q + 1'b1;
            end
          end
        end
        StMemRead: begin
          // The first edge only marks the request as issued, so a fill never
          // completes on a stale mem_busywait=0 seen before memory reacted.
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (!mem_busywait) begin
            state_q    <= StUpdate;
            mem_read_q <= 1'b0;
            issued_q   <= 1'b0;
            block_q    <= mem_readinst;
          end
        end
        StUpdate: begin
          valid_q[fill_index] <= 1'b1;
          state_q             <= StIdle;
        end
        StFlush: begin
          valid_q <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data storage; written only in UPDATE, never reset.
  always_ff @(posedge clock) begin
    if (state_q == StUpdate) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= block_q;
    end
  end

endmodule
